// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the dual-clock byte FIFO. Synchronises the Gray write
// pointer, owns the read pointer, and presents memory data as first-word-fall-through
// with a one-entry skid register so a ready consumer sees one word per cycle.
module async_fifo_rd_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned AEMPTY_THR = 4
) (
  input  logic              clk_rd,
  input  logic              rst,
  input  logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [ADDR_W:0]   rd_count,
  output logic              buf_empty,
  output logic              almost_empty
);

  localparam int unsigned PtrW = ADDR_W + 1;
  localparam logic [ADDR_W:0] AEmptyThr = PtrW'(AEMPTY_THR);

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = int'(ADDR_W) - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [ADDR_W:0]   wr_sync1_q, wr_sync2_q;
  logic [ADDR_W:0]   wr_bin_s;
  logic [ADDR_W:0]   rd_ptr_bin_q, rd_ptr_bin_inc;
  logic              pending_q;
  logic [DATA_W-1:0] skid_q, skid_d, dout_d;
  logic              skid_valid_q, skid_valid_d, dout_valid_d;
  logic              avail, pop;
  logic [1:0]        used;

  assign wr_bin_s       = gray2bin(wr_sync2_q);
  assign rd_count       = wr_bin_s - rd_ptr_bin_q;
  assign avail          = (rd_count != '0);
  assign pop            = dout_valid & dout_ready;
  // Slots already committed: held word, skid word and the word in flight from memory.
  assign used           = {1'b0, dout_valid} + {1'b0, skid_valid_q} + {1'b0, pending_q};
  assign mem_rd_en      = avail & ((used - {1'b0, pop}) < 2'd2);
  assign mem_rd_addr    = rd_ptr_bin_q[ADDR_W-1:0];
  assign rd_ptr_bin_inc = rd_ptr_bin_q + 1'b1;
  assign buf_empty      = ~avail & ~pending_q & ~dout_valid & ~skid_valid_q;
  assign almost_empty   = (rd_count <= AEmptyThr);

  // Two-flop synchroniser on the incoming Gray write pointer.
  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      wr_sync1_q <= '0;
      wr_sync2_q <= '0;
    end else begin
      wr_sync1_q <= wr_ptr_gray;
      wr_sync2_q <= wr_sync1_q;
    end
  end

  // Read pointer (binary and exported Gray) advance on each fetch; pending tracks in-flight data.
  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      rd_ptr_bin_q <= '0;
      rd_ptr_gray  <= '0;
      pending_q    <= 1'b0;
    end else begin
      pending_q <= mem_rd_en;
      if (mem_rd_en) begin
        rd_ptr_bin_q <= rd_ptr_bin_inc;
        rd_ptr_gray  <= bin2gray(rd_ptr_bin_inc);
      end
    end
  end

  // Route the landing word and the skid entry into the output register, preserving order.
  always_comb begin
    dout_d       = dout;
    dout_valid_d = dout_valid;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (pending_q) begin
      if (!dout_valid) begin
        dout_d       = mem_rd_data;
        dout_valid_d = 1'b1;
      end else if (pop) begin
        if (skid_valid_q) begin
          // Older skid word goes out first; the landing word takes its place.
          dout_d = skid_q;
          skid_d = mem_rd_data;
        end else begin
          dout_d = mem_rd_data;
        end
      end else begin
        skid_d       = mem_rd_data;
        skid_valid_d = 1'b1;
      end
    end else if (pop) begin
      if (skid_valid_q) begin
        dout_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        dout_valid_d = 1'b0;
      end
    end
  end

  // Output and skid registers.
  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      dout         <= '0;
      dout_valid   <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      dout         <= dout_d;
      dout_valid   <= dout_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Bench for async_fifo_rd_ctrl: behavioural memory plus an in-order queue of written bytes.
module tb_async_fifo_rd_ctrl;

  logic       clk_rd;
  logic       rst;
  logic [6:0] wr_ptr_gray;
  logic [6:0] rd_ptr_gray;
  logic       mem_rd_en;
  logic [5:0] mem_rd_addr;
  logic [7:0] mem_rd_data;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [6:0] rd_count;
  logic       buf_empty;
  logic       almost_empty;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [64];
  logic [7:0] exp_q [$];
  logic [6:0] wb;
  logic [6:0] prev_gray;
  logic       saw_wrap;

  async_fifo_rd_ctrl #(
    .DATA_W    (8),
    .ADDR_W    (6),
    .AEMPTY_THR(4)
  ) dut (
    .clk_rd      (clk_rd),
    .rst         (rst),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .rd_count    (rd_count),
    .buf_empty   (buf_empty),
    .almost_empty(almost_empty)
  );

  initial clk_rd = 1'b0;
  always #5 clk_rd = ~clk_rd;

  // Synchronous-read memory model.
  always @(posedge clk_rd) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  function automatic logic [6:0] to_gray(input logic [6:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic write_word(input logic [7:0] v);
    mem[wb[5:0]] = v;
    exp_q.push_back(v);
    wb = wb + 7'd1;
    wr_ptr_gray = to_gray(wb);
  endtask

  // Random or patterned traffic with in-order scoreboard and stall-stability check.
  task automatic run_traffic(input int n, input int mode, input int budget);
    int left = n;
    int cyc = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [7:0] pd = '0;
    prev_gray = rd_ptr_gray;
    while ((left > 0 || exp_q.size() > 0 || buf_empty !== 1'b1) && cyc < budget) begin
      @(negedge clk_rd);
      cyc++;
      if (pv && !pr) begin
        checks++;
        if (dout_valid !== 1'b1 || dout !== pd) begin
          errors++;
          $display("FAIL stall_stable got valid=%b dout=%h want valid=1 dout=%h",
                   dout_valid, dout, pd);
        end
      end
      if (prev_gray == 7'b1000000 && rd_ptr_gray == 7'b0000000) saw_wrap = 1'b1;
      prev_gray = rd_ptr_gray;
      case (mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = 1'($urandom_range(0, 1));
        default: dout_ready = ~dout_ready;
      endcase
      if (left > 0 && exp_q.size() < 64 && $urandom_range(0, 1) == 1) begin
        write_word(8'($urandom));
        left--;
      end
      if (dout_valid && dout_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected got dout=%h want no valid word", dout);
        end else begin
          if (dout !== exp_q[0]) begin
            errors++;
            $display("FAIL pop_data got %h want %h", dout, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      pv = dout_valid;
      pr = dout_ready;
      pd = dout;
    end
    checks++;
    if (left != 0 || exp_q.size() != 0 || buf_empty !== 1'b1) begin
      errors++;
      $display("FAIL traffic_done got left=%0d queued=%0d buf_empty=%b want 0 0 1",
               left, exp_q.size(), buf_empty);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_ptr_gray = '0;
    dout_ready = 1'b0;
    wb = '0;
    #3;
    checks++;
    if (dout_valid !== 1'b0 || buf_empty !== 1'b1 || rd_ptr_gray !== 7'd0 ||
        rd_count !== 7'd0 || almost_empty !== 1'b1 || mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b be=%b g=%h c=%0d ae=%b en=%b want 0 1 0 0 1 0",
               dout_valid, buf_empty, rd_ptr_gray, rd_count, almost_empty, mem_rd_en);
    end
    @(negedge clk_rd);
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    @(negedge clk_rd);
    dout_ready = 1'b0;
    write_word(8'hA5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_rd);
      checks++;
      if (dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_early edge %0d got valid=%b want 0", k, dout_valid);
      end
    end
    @(negedge clk_rd);
    checks++;
    if (dout !== 8'hA5 || dout_valid !== 1'b1 || rd_ptr_gray !== 7'd1 ||
        rd_count !== 7'd0 || buf_empty !== 1'b0) begin
      errors++;
      $display("FAIL single_word got d=%h v=%b g=%h c=%0d be=%b want a5 1 1 0 0",
               dout, dout_valid, rd_ptr_gray, rd_count, buf_empty);
    end
    dout_ready = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk_rd);
    dout_ready = 1'b0;
    checks++;
    if (buf_empty !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop got be=%b v=%b want 1 0", buf_empty, dout_valid);
    end
  endtask

  task automatic test_streaming();
    int rc;
    @(negedge clk_rd);
    for (int i = 0; i < 64; i++) write_word(8'(i));
    dout_ready = 1'b1;
    @(posedge clk_rd);
    for (int j = 0; j < 68; j++) begin
      @(posedge clk_rd);
      @(negedge clk_rd);
      rc = (j <= 64) ? 64 - j : 0;
      checks++;
      if (rd_count !== 7'(rc) || almost_empty !== (rc <= 4) || mem_rd_en !== (rc != 0)) begin
        errors++;
        $display("FAIL stream_count j=%0d got c=%0d ae=%b en=%b want %0d %b %b",
                 j, rd_count, almost_empty, mem_rd_en, rc, rc <= 4, rc != 0);
      end
      checks++;
      if (dout_valid !== (j >= 2 && j <= 65) || (dout_valid && dout !== 8'(j - 2))) begin
        errors++;
        $display("FAIL stream_data j=%0d got v=%b d=%h want v=%b d=%h",
                 j, dout_valid, dout, (j >= 2 && j <= 65), 8'(j - 2));
      end
      if (dout_valid) void'(exp_q.pop_front());
      if (j >= 66) begin
        checks++;
        if (buf_empty !== 1'b1) begin
          errors++;
          $display("FAIL stream_empty j=%0d got %b want 1", j, buf_empty);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] first;
    @(negedge clk_rd);
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(8'($urandom));
    first = exp_q[0];
    repeat (10) @(negedge clk_rd);
    checks++;
    if (rd_count !== 7'd6 || mem_rd_en !== 1'b0 || dout_valid !== 1'b1 || dout !== first) begin
      errors++;
      $display("FAIL backpressure got c=%0d en=%b v=%b d=%h want 6 0 1 %h",
               rd_count, mem_rd_en, dout_valid, dout, first);
    end
    run_traffic(0, 2, 100);
  endtask

  task automatic test_wrap();
    // Bring both pointers to 120 so the next 16 words cross 127 -> 0.
    run_traffic(47, 1, 2000);
    checks++;
    if (rd_ptr_gray !== to_gray(7'd120)) begin
      errors++;
      $display("FAIL wrap_preload got %h want %h", rd_ptr_gray, to_gray(7'd120));
    end
    saw_wrap = 1'b0;
    run_traffic(16, 0, 300);
    checks++;
    if (saw_wrap !== 1'b1 || rd_count !== 7'd0 || rd_ptr_gray !== to_gray(7'd8)) begin
      errors++;
      $display("FAIL wrap got seen=%b c=%0d g=%h want 1 0 %h",
               saw_wrap, rd_count, rd_ptr_gray, to_gray(7'd8));
    end
  endtask

  task automatic test_random();
    run_traffic(200, 1, 5000);
  endtask

  task automatic test_reset_midstream();
    @(negedge clk_rd);
    dout_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_word(8'($urandom));
    repeat (8) @(negedge clk_rd);
    checks++;
    if (rd_count !== 7'd4 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL midstream_setup got c=%0d v=%b want 4 1", rd_count, dout_valid);
    end
    // Pop once so skid drains into dout while a fresh fetch is in flight.
    dout_ready = 1'b1;
    @(posedge clk_rd);
    #2;
    rst = 1'b1;
    wr_ptr_gray = '0;
    dout_ready = 1'b0;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || buf_empty !== 1'b1 || rd_ptr_gray !== 7'd0 ||
        rd_count !== 7'd0 || mem_rd_en !== 1'b0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL midstream_reset got v=%b be=%b g=%h c=%0d en=%b d=%h want 0 1 0 0 0 00",
               dout_valid, buf_empty, rd_ptr_gray, rd_count, mem_rd_en, dout);
    end
    exp_q.delete();
    wb = '0;
    @(negedge clk_rd);
    rst = 1'b0;
    dout_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_rd);
      checks++;
      if (dout_valid !== 1'b0 || buf_empty !== 1'b1 || mem_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle k=%0d got v=%b be=%b en=%b want 0 1 0",
                 k, dout_valid, buf_empty, mem_rd_en);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset();
    test_single_word();
    test_streaming();
    test_backpressure();
    test_wrap();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
